// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, framer states
// and the data width.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic [1:0] NOPARITY00 = 2'b00;
  localparam logic [1:0] ODD        = 2'b01;
  localparam logic [1:0] EVEN       = 2'b10;
  localparam logic [1:0] NOPARITY11 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Both "no parity" encodings suppress the parity bit.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    logic en;
    case (ptype)
      ODD, EVEN:              en = 1'b1;
      NOPARITY00, NOPARITY11: en = 1'b0;
      default:                en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick_o on the
// last count of every bit period. Synchronous clear restarts the period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_cnt;

  assign last_cnt = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = en_i && last_cnt;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
// Optional line-break input is enabled with `define UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_type,
  input  logic                 two_stop,
  input  logic                 parity_bit,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic [DATA_BITS-1:0] pg_data,
  output logic [1:0]           pg_parity_type,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] data_q;
  logic [1:0]           ptype_q;
  logic                 two_stop_q;
  logic                 stop2_q;
  logic [IdxW-1:0]      idx_q;
  logic [IdxW-1:0]      idx_nxt;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic break_req;
  logic accept;
  logic bit_tick;

`ifdef UART_TX_BREAK_EN
  assign break_req = tx_break;
`else
  assign break_req = 1'b0;
`endif

  assign accept  = (state_q == IDLE) && send && !break_req;
  assign idx_nxt = idx_q + 1'b1;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_cnt (
    .clk_i     (clock),
    .rst_i     (reset),
    .clr_i     (accept),
    .en_i      (busy_q),
    .bit_tick_o(bit_tick)
  );

  // tx_q is loaded with the value of the bit being entered, so the line changes on
  // the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      ptype_q    <= NOPARITY00;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= ~break_req;
          if (accept) begin
            data_q     <= data_in;
            ptype_q    <= parity_type;
            two_stop_q <= two_stop;
            stop2_q    <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            idx_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (idx_q == LastIdx) begin
              idx_q <= '0;
              if (parity_enabled(ptype_q)) begin
                tx_q    <= parity_bit;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q <= idx_nxt;
              tx_q  <= data_q[idx_nxt];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (two_stop_q && !stop2_q) begin
              stop2_q <= 1'b1;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pg_data        = data_q;
  assign pg_parity_type = ptype_q;
  assign tx_out         = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver queues expected frames, a monitor
// captures each busy window from the serial line and checks it against the queue.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int C = 4;

  logic       clock = 1'b0;
  logic       reset, send, two_stop, parity_bit;
  logic       tx_out, busy, done;
  logic [7:0] data_in, pg_data;
  logic [1:0] parity_type, pg_parity_type;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [0:11] seq;
    int          nbits;
    bit          aborted;
    int          abort_len;
  } exp_t;

  exp_t exp_q[$];

  logic samp[$];
  bit   in_frame = 1'b0;
  bit   early_done = 1'b0;
  int   fr = 0;
  exp_t e;

  always #5 clock = ~clock;

  // Downstream parity generator model.
  assign parity_bit = (pg_parity_type == 2'b01) ? ~(^pg_data) :
                      (pg_parity_type == 2'b10) ?  (^pg_data) : 1'b0;

  uart_tx_frame #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .send          (send),
    .data_in       (data_in),
    .parity_type   (parity_type),
    .two_stop      (two_stop),
    .parity_bit    (parity_bit),
`ifdef UART_TX_BREAK_EN
    .tx_break      (tx_break),
`endif
    .pg_data       (pg_data),
    .pg_parity_type(pg_parity_type),
    .tx_out        (tx_out),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [0:11] seq, input int nbits);
    exp_t x;
    x.seq = seq;
    x.nbits = nbits;
    x.aborted = 1'b0;
    x.abort_len = 0;
    exp_q.push_back(x);
  endtask

  task automatic push_abort(input int len);
    exp_t x;
    x.seq = '0;
    x.nbits = 0;
    x.aborted = 1'b1;
    x.abort_len = len;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic ts);
    @(negedge clock);
    data_in = d;
    parity_type = pt;
    two_stop = ts;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_completes"}, int'(busy === 1'b1), 0);
  endtask

  // Monitor: one capture per busy window, compared at the cycle busy falls.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          early_done = 1'b0;
          samp.delete();
        end
        samp.push_back(tx_out);
        if (done === 1'b1) early_done = 1'b1;
      end else if (in_frame) begin
        in_frame = 1'b0;
        fr++;
        if (exp_q.size() == 0) begin
          chk($sformatf("frame%0d_expected", fr), 0, 1);
        end else begin
          e = exp_q.pop_front();
          if (e.aborted) begin
            chk($sformatf("frame%0d_abort_no_done", fr), int'(done === 1'b1), 0);
            chk($sformatf("frame%0d_abort_len", fr), samp.size(), e.abort_len);
          end else begin
            chk($sformatf("frame%0d_done_at_end", fr), int'(done === 1'b1), 1);
            chk($sformatf("frame%0d_no_early_done", fr), int'(early_done), 0);
            chk($sformatf("frame%0d_len", fr), samp.size(), e.nbits * C);
            for (int i = 0; i < samp.size() && i < e.nbits * C; i++) begin
              chk($sformatf("frame%0d_bit%0d_clk%0d", fr, i / C, i % C),
                  int'(samp[i]), int'(e.seq[i / C]));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1;
    send = 1'b0;
    data_in = '0;
    parity_type = 2'b00;
    two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_tx_out", int'(tx_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pg_data", int'(pg_data), 0);
    chk("rst_pg_parity_type", int'(pg_parity_type), 0);
    reset = 1'b0;
    @(negedge clock);

    // A5, no parity, one stop; a mid-frame send must be ignored.
    push_frame(12'b0_10100101_1_00, 10);
    send_frame(8'hA5, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    data_in = 8'hFF;
    parity_type = 2'b10;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    wait_idle("t1", 100);
    @(negedge clock);

    // 07, even parity -> parity bit 1.
    push_frame(12'b0_11100000_1_1_0, 11);
    send_frame(8'h07, 2'b10, 1'b0);
    wait_idle("t2", 100);
    @(negedge clock);

    // 07, odd parity, two stops -> parity bit 0, 48 clocks.
    push_frame(12'b0_11100000_0_11, 12);
    send_frame(8'h07, 2'b01, 1'b1);
    wait_idle("t3", 100);
    chk("t3_pg_data_held", int'(pg_data), 8'h07);
    chk("t3_pg_ptype_held", int'(pg_parity_type), 2'b01);
    @(negedge clock);

    // send held high: 81 (type 11 = no parity), then 3C odd back to back.
    push_frame(12'b0_10000001_1_00, 10);
    push_frame(12'b0_00111100_1_1_0, 11);
    @(negedge clock);
    data_in = 8'h81;
    parity_type = 2'b11;
    two_stop = 1'b0;
    send = 1'b1;
    repeat (20) @(negedge clock);
    data_in = 8'h3C;
    parity_type = 2'b01;
    repeat (30) @(negedge clock);
    send = 1'b0;
    wait_idle("t4", 200);
    @(negedge clock);

    // Reset at clock 15 of a frame, then a clean frame.
    push_abort(15);
    send_frame(8'hA5, 2'b10, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_tx_out", int'(tx_out), 1);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("t5_no_late_done", int'(done), 0);
    push_frame(12'b0_01011010_0_11, 12);
    send_frame(8'h5A, 2'b10, 1'b1);
    wait_idle("t5", 100);
    @(negedge clock);

`ifdef UART_TX_BREAK_EN
    // Break in IDLE blocks send; release restores the line; mid-frame break waits.
    tx_break = 1'b1;
    data_in = 8'h55;
    send = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_break_line_low", int'(tx_out), 0);
    chk("t6_break_blocks_send", int'(busy), 0);
    send = 1'b0;
    tx_break = 1'b0;
    @(negedge clock);
    chk("t6_release_line_high", int'(tx_out), 1);
    push_frame(12'b0_10000000_1_00, 10);
    send_frame(8'h01, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    tx_break = 1'b1;
    wait_idle("t6", 100);
    chk("t6_line_high_at_done", int'(tx_out), 1);
    @(negedge clock);
    chk("t6_break_after_frame", int'(tx_out), 0);
    tx_break = 1'b0;
    @(negedge clock);
    chk("t6_release_again", int'(tx_out), 1);
`endif

    repeat (3) @(negedge clock);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
